// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } hazard_state_t;

  localparam logic [4:0] REG_X0         = 5'd0;
  localparam int         LOAD_STALL_MAX = 7;

  // True when a source register is both read and written by the load ahead of it.
  function automatic logic src_match(input logic used, input logic [4:0] rs,
                                     input logic [4:0] rd);
    return used && (rs == rd);
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating stall/flush event counters, present only with HAZARD_PERF_CNT_EN.
module hazard_perf_cnt (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall and branch flush control for the ID stage.
// Optional perf counters (StallCnt_o, FlushCnt_o) are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int LOAD_STALL = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [4:0]    IF_ID_RS1addr_i,
  input  logic [4:0]    IF_ID_RS2addr_i,
  input  logic          RS1used_i,
  input  logic          RS2used_i,
  input  logic [4:0]    ID_EX_RDaddr_i,
  input  logic          ID_EX_MemRead_i,
  input  logic          BranchTaken_i,
  output logic          hazard_o,
  output logic          PCWrite_o,
  output logic          IF_IDWrite_o,
  output logic          Flush_o,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]   StallCnt_o,
  output logic [31:0]   FlushCnt_o,
`endif
  output hazard_state_t dbg_state
);

  // Out-of-range settings are clamped into 1..LOAD_STALL_MAX.
  localparam int STALL_N = (LOAD_STALL < 1) ? 1 :
                           (LOAD_STALL > LOAD_STALL_MAX) ? LOAD_STALL_MAX : LOAD_STALL;
  localparam int CW      = $clog2(STALL_N + 1);

  hazard_state_t state;
  logic [CW-1:0] cnt;
  logic          load_use;

  assign load_use = ID_EX_MemRead_i && (ID_EX_RDaddr_i != REG_X0) &&
                    (src_match(RS1used_i, IF_ID_RS1addr_i, ID_EX_RDaddr_i) ||
                     src_match(RS2used_i, IF_ID_RS2addr_i, ID_EX_RDaddr_i));

  assign dbg_state = state;

  // Outputs stay combinational so the bubble lands in the detection cycle.
  always_comb begin
    hazard_o     = 1'b0;
    PCWrite_o    = 1'b1;
    IF_IDWrite_o = 1'b1;
    Flush_o      = 1'b0;
    if (rst_i) begin
      case (state)
        RUN: begin
          if (BranchTaken_i) begin
            hazard_o = 1'b1;
            Flush_o  = 1'b1;
          end else if (load_use) begin
            hazard_o     = 1'b1;
            PCWrite_o    = 1'b0;
            IF_IDWrite_o = 1'b0;
          end
        end
        STALL: begin
          hazard_o = 1'b1;
          if (BranchTaken_i) begin
            Flush_o = 1'b1;
          end else begin
            PCWrite_o    = 1'b0;
            IF_IDWrite_o = 1'b0;
          end
        end
        FLUSH: hazard_o = 1'b1;
        default: ;
      endcase
    end
  end

  // STALL carries the remaining bubbles because ID_EX no longer holds the load.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (BranchTaken_i) begin
            state <= FLUSH;
          end else if (load_use && (STALL_N > 1)) begin
            cnt   <= CW'(STALL_N - 1);
            state <= STALL;
          end
        end
        STALL: begin
          if (BranchTaken_i || (cnt <= CW'(1))) begin
            cnt   <= '0;
            state <= RUN;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        FLUSH:   state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt u_perf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .stall     (!PCWrite_o),
    .flush     (Flush_o),
    .stall_cnt (StallCnt_o),
    .flush_cnt (FlushCnt_o)
  );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances (LOAD_STALL = 1, 2, 3) share one set of inputs.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam logic [3:0] E_PASS = 4'b0110;  // {hazard, PCWrite, IF_IDWrite, Flush}
  localparam logic [3:0] E_STL  = 4'b1000;
  localparam logic [3:0] E_BRF  = 4'b1111;
  localparam logic [3:0] E_FLS  = 4'b1110;

  logic       clk;
  logic       rst;
  logic [4:0] rs1, rs2, rd;
  logic       rs1_used, rs2_used, mem_read, br;

  logic          hz  [3];
  logic          pcw [3];
  logic          ifw [3];
  logic          fl  [3];
  hazard_state_t st  [3];
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] scnt [3];
  logic [31:0] fcnt [3];
`endif

  int n_tests = 0;
  int n_fail  = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    hazard_ctrl #(.LOAD_STALL(g + 1)) u_dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .IF_ID_RS1addr_i (rs1),
      .IF_ID_RS2addr_i (rs2),
      .RS1used_i       (rs1_used),
      .RS2used_i       (rs2_used),
      .ID_EX_RDaddr_i  (rd),
      .ID_EX_MemRead_i (mem_read),
      .BranchTaken_i   (br),
      .hazard_o        (hz[g]),
      .PCWrite_o       (pcw[g]),
      .IF_IDWrite_o    (ifw[g]),
      .Flush_o         (fl[g]),
`ifdef HAZARD_PERF_CNT_EN
      .StallCnt_o      (scnt[g]),
      .FlushCnt_o      (fcnt[g]),
`endif
      .dbg_state       (st[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] outs(input int k);
    return {hz[k], pcw[k], ifw[k], fl[k]};
  endfunction

  // Inputs change 1 time unit after the rising edge; checks happen 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_quiet();
    rs1 = 5'd1; rs2 = 5'd2; rs1_used = 1'b1; rs2_used = 1'b1;
    rd = 5'd0; mem_read = 1'b0; br = 1'b0;
  endtask

  // lw x5 in ID_EX, add x6,x5,x1 in IF_ID.
  task automatic set_load_use();
    rs1 = 5'd5; rs2 = 5'd1; rs1_used = 1'b1; rs2_used = 1'b1;
    rd = 5'd5; mem_read = 1'b1; br = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    set_quiet();
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_load_use();
    tick();
    tick();
    #1;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (outs(k) !== E_PASS) begin
        n_fail++;
        $display("FAIL reset_hold dut%0d: got %b expected %b", k, outs(k), E_PASS);
      end
    end
    tick();
    rst = 1'b1;
    set_quiet();
    #1;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (outs(k) !== E_PASS || st[k] !== RUN) begin
        n_fail++;
        $display("FAIL reset_release dut%0d: got %b/%0d expected %b/RUN", k, outs(k), st[k], E_PASS);
      end
    end
  endtask

  // After the detection cycle ID_EX holds a bubble, yet each instance keeps stalling LOAD_STALL cycles.
  task automatic test_load_stall();
    set_load_use();
    for (int c = 0; c < 4; c++) begin
      #1;
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (outs(k) !== ((c < k + 1) ? E_STL : E_PASS)) begin
          n_fail++;
          $display("FAIL load_stall dut%0d cyc%0d: got %b expected %b", k, c, outs(k),
                   (c < k + 1) ? E_STL : E_PASS);
        end
      end
      tick();
      set_quiet();
      rs1 = 5'd5;
    end
  endtask

  task automatic test_no_stall();
    set_load_use();
    rd = 5'd0; rs1 = 5'd0;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (outs(k) !== E_PASS) begin
        n_fail++;
        $display("FAIL rd_x0 dut%0d: got %b expected %b", k, outs(k), E_PASS);
      end
    end
    tick();
    set_load_use();
    rs1 = 5'd1; rs2 = 5'd5; rs2_used = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (outs(k) !== E_PASS) begin
        n_fail++;
        $display("FAIL rs2_unused dut%0d: got %b expected %b", k, outs(k), E_PASS);
      end
    end
    tick();
    set_quiet();
  endtask

  task automatic test_branch_priority();
    set_load_use();
    br = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (outs(k) !== E_BRF) begin
        n_fail++;
        $display("FAIL branch_vs_load dut%0d: got %b expected %b", k, outs(k), E_BRF);
      end
    end
    tick();
    set_quiet();
    #1;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (outs(k) !== E_FLS || st[k] !== FLUSH) begin
        n_fail++;
        $display("FAIL flush_cycle dut%0d: got %b/%0d expected %b/FLUSH", k, outs(k), st[k], E_FLS);
      end
    end
    tick();
    #1;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (outs(k) !== E_PASS) begin
        n_fail++;
        $display("FAIL after_flush dut%0d: got %b expected %b", k, outs(k), E_PASS);
      end
    end
  endtask

  // Branch on the cycle after detection: instances still stalling flush and go straight to RUN.
  task automatic test_branch_in_stall();
    logic [3:0] exp2 [3];
    set_load_use();
    tick();
    set_quiet();
    br = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (outs(k) !== E_BRF) begin
        n_fail++;
        $display("FAIL branch_in_stall dut%0d: got %b expected %b", k, outs(k), E_BRF);
      end
    end
    tick();
    br = 1'b0;
    #1;
    exp2[0] = E_FLS; exp2[1] = E_PASS; exp2[2] = E_PASS;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (outs(k) !== exp2[k]) begin
        n_fail++;
        $display("FAIL post_branch_in_stall dut%0d: got %b expected %b", k, outs(k), exp2[k]);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    set_load_use();
    tick();
    set_quiet();
    rs1 = 5'd5;
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (outs(k) !== E_PASS) begin
        n_fail++;
        $display("FAIL reset_mid_stall dut%0d: got %b expected %b", k, outs(k), E_PASS);
      end
    end
    tick();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (outs(k) !== E_PASS || st[k] !== RUN) begin
          n_fail++;
          $display("FAIL stall_aborted dut%0d cyc%0d: got %b/%0d expected %b/RUN", k, c, outs(k), st[k], E_PASS);
        end
      end
      tick();
    end
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf_cnt();
    int exp_s [3];
    do_reset();
    set_load_use(); tick();
    set_quiet();    tick();
    set_load_use(); tick();
    set_quiet();    tick();
    br = 1'b1;      tick();
    set_quiet();    tick();
    tick();
    exp_s[0] = 2; exp_s[1] = 4; exp_s[2] = 3;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (scnt[k] !== exp_s[k] || fcnt[k] !== 32'd1) begin
        n_fail++;
        $display("FAIL perf_cnt dut%0d: got %0d/%0d expected %0d/1", k, scnt[k], fcnt[k], exp_s[k]);
      end
    end
  endtask
`endif

  // Reference: a hazard reserves the next LOAD_STALL-1 cycles as stall cycles,
  // a branch outside a stall reserves the following cycle as the flush cycle.
  task automatic test_random();
    int         stall_end [3];
    int         flush_at  [3];
    int         stalls    [3];
    int         flushes   [3];
    logic [3:0] e;
    logic       lu;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      stall_end[k] = 0; flush_at[k] = -10; stalls[k] = 0; flushes[k] = 0;
    end
    for (int n = 0; n < 300; n++) begin
      rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
      rd  = 5'($urandom_range(0, 3));
      rs1_used = 1'($urandom_range(0, 1)); rs2_used = 1'($urandom_range(0, 1));
      mem_read = 1'($urandom_range(0, 1));
      br = ($urandom_range(0, 5) == 0);
      lu = mem_read && (rd != 0) && ((rs1_used && rs1 == rd) || (rs2_used && rs2 == rd));
      #1;
      for (int k = 0; k < 3; k++) begin
        if (n == flush_at[k] + 1) e = E_FLS;
        else if (n < stall_end[k]) begin
          if (br) begin e = E_BRF; stall_end[k] = n; end
          else e = E_STL;
        end else if (br) begin e = E_BRF; flush_at[k] = n; end
        else if (lu) begin e = E_STL; stall_end[k] = n + k + 1; end
        else e = E_PASS;
        if (!e[2]) stalls[k]++;
        if (e[0]) flushes[k]++;
        n_tests++;
        if (outs(k) !== e) begin
          n_fail++;
          $display("FAIL random dut%0d cyc%0d: got %b expected %b", k, n, outs(k), e);
        end
      end
      tick();
    end
`ifdef HAZARD_PERF_CNT_EN
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (scnt[k] !== stalls[k] || fcnt[k] !== flushes[k]) begin
        n_fail++;
        $display("FAIL random_perf dut%0d: got %0d/%0d expected %0d/%0d", k, scnt[k], fcnt[k], stalls[k], flushes[k]);
      end
    end
`endif
    set_quiet();
  endtask

  initial begin
    rst = 1'b0;
    set_quiet();
    test_reset();
    tick();
    test_load_stall();
    test_no_stall();
    test_branch_priority();
    test_branch_in_stall();
    test_reset_mid_stall();
`ifdef HAZARD_PERF_CNT_EN
    test_perf_cnt();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller in the ID stage that drives the control-bubble mux between Control and ID_EX. It detects load-use hazards between the instruction in IF_ID and a load in ID_EX, and raises `hazard_o` to zero the control fields entering ID_EX. It freezes PC and IF_ID for a configurable number of cycles and flushes IF_ID on a taken branch. It holds multi-cycle stalls in a small FSM, because the bubble it inserts removes the load from ID_EX after the first stall cycle.

## Interface
Parameters:
- `LOAD_STALL`, default 1: bubbles inserted per load-use hazard; legal range 1..7.

Ports:
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: reset, synchronous, active-low.
- `IF_ID_RS1addr_i` in 5: rs1 of the instruction in IF_ID.
- `IF_ID_RS2addr_i` in 5: rs2 of the instruction in IF_ID.
- `RS1used_i` in 1: instruction in IF_ID reads rs1 (from Control).
- `RS2used_i` in 1: instruction in IF_ID reads rs2.
- `ID_EX_RDaddr_i` in 5: rd of the instruction in ID_EX.
- `ID_EX_MemRead_i` in 1: instruction in ID_EX is a load.
- `BranchTaken_i` in 1: branch/jump resolved taken this cycle.
- `hazard_o` out 1: to the bubble mux; 1 forces zero control into ID_EX.
- `PCWrite_o` out 1: PC write enable.
- `IF_IDWrite_o` out 1: IF_ID write enable.
- `Flush_o` out 1: IF_ID clear (turns the instruction into a NOP).

## Operation
- `load_use = ID_EX_MemRead_i & (ID_EX_RDaddr_i != 0) & ((RS1used_i & rd==rs1) | (RS2used_i & rd==rs2))`.
- FSM states: RUN, STALL, FLUSH. Reset state is RUN with cnt = 0.
- RUN:
  - If `BranchTaken_i` is high: `Flush_o`=1 and `hazard_o`=1 (the ID instruction is wrong-path); PC writes; go to FLUSH. This takes priority over `load_use`.
  - Else if `load_use`: `hazard_o`=1, `PCWrite_o`=0, `IF_IDWrite_o`=0. If `LOAD_STALL`>1, load cnt = `LOAD_STALL`-1 and go to STALL; otherwise stay in RUN.
  - Else pass through: `hazard_o`=0, `PCWrite_o`=1, `IF_IDWrite_o`=1, `Flush_o`=0.
- STALL:
  - Outputs are `hazard_o`=1, `PCWrite_o`=0, `IF_IDWrite_o`=0. Decrement cnt and return to RUN when cnt reaches 1.
  - If `BranchTaken_i` is high, flush wins: cnt is cleared, FLUSH outputs are applied, and the next state is RUN.
- FLUSH: one cycle. `hazard_o`=1, `Flush_o`=0, PC and IF_ID write. Next state is RUN, where detection runs normally.
- rd = x0 never stalls, and an unused source never stalls.
- cnt width is `$clog2(LOAD_STALL+1)`; cnt never wraps below 0.

## Timing
- Detection is combinational from inputs to `hazard_o`, `PCWrite_o` and `IF_IDWrite_o` in the same cycle; the bubble mux is combinational into ID_EX.
- A load-use hazard yields exactly `LOAD_STALL` consecutive cycles of `hazard_o`=1, starting in the detection cycle.
- `Flush_o` is high for exactly 1 cycle per taken branch.
- Output values while reset is asserted and on the first cycle after release: `hazard_o`=0, `PCWrite_o`=1, `IF_IDWrite_o`=1, `Flush_o`=0.
- Reset asserted mid-STALL or mid-FLUSH aborts the stall or flush at the next edge: state returns to RUN and cnt to 0.

## Configuration
- `HAZARD_PERF_CNT_EN` defined: adds output ports `StallCnt_o` [31:0] and `FlushCnt_o` [31:0].
  - `StallCnt_o` increments on each cycle with `PCWrite_o`=0.
  - `FlushCnt_o` increments on each cycle with `Flush_o`=1.
  - Both counters are zero on reset, saturate at 2^32-1, and are otherwise free-running.
- `HAZARD_PERF_CNT_EN` undefined: the ports and counters are absent, and the behaviour is otherwise identical.

## Structure
- Package `hazard_pkg` holds:
  - the state enum `hazard_state_t` {RUN, STALL, FLUSH};
  - the constant `REG_X0` = 5'd0;
  - the constant `LOAD_STALL_MAX` = 7.
- Sub-module `hazard_perf_cnt` holds the two saturating counters. It is instantiated only under `HAZARD_PERF_CNT_EN`.

## Test plan
- Load x5 in ID_EX, add x6,x5,x1 in IF_ID, `LOAD_STALL`=1 -> one cycle with `hazard_o`=1 and `PCWrite_o`=0, then pass-through.
- Same stimulus with `LOAD_STALL`=3 -> `hazard_o`=1 for 3 consecutive cycles even though ID_EX holds a bubble after cycle 1, then RUN.
- Load x0 with matching rs, or load x5 with `RS2used_i`=0 and rs2=5 -> no stall, `hazard_o`=0 throughout.
- `BranchTaken_i` and `load_use` in the same cycle -> `Flush_o`=1 and `PCWrite_o`=1, no stall, FLUSH for 1 cycle, then RUN.
- `rst_i`=0 during the second cycle of a 3-cycle stall -> on the next edge outputs return to the reset values and cnt = 0.
- With `HAZARD_PERF_CNT_EN` defined: two loads with `LOAD_STALL`=2 plus one taken branch -> `StallCnt_o`=4 and `FlushCnt_o`=1.
